// File: rtl/order_tx_serializer.sv
// Buffers buy/sell register pairs in a FIFO and streams them as 32-bit words, buy first, then sell.
// Latency: first word is valid two cycles after i_valid. Backpressure: i_tx_ready stalls output and full FIFO drops new pairs.
module order_tx_serializer #(
  parameter int REG_WIDTH  = 32,
  parameter int NUM_REGS   = 9,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                               i_clk,
  input  logic                               i_reset_n,
  input  logic                               i_valid,
  input  logic [REG_WIDTH-1:0]               i_reg_0_b,
  input  logic [REG_WIDTH-1:0]               i_reg_1_b,
  input  logic [REG_WIDTH-1:0]               i_reg_2_b,
  input  logic [REG_WIDTH-1:0]               i_reg_3_b,
  input  logic [REG_WIDTH-1:0]               i_reg_4_b,
  input  logic [REG_WIDTH-1:0]               i_reg_5_b,
  input  logic [REG_WIDTH-1:0]               i_reg_6_b,
  input  logic [REG_WIDTH-1:0]               i_reg_7_b,
  input  logic [REG_WIDTH-1:0]               i_reg_8_b,
  input  logic [REG_WIDTH-1:0]               i_reg_0_s,
  input  logic [REG_WIDTH-1:0]               i_reg_1_s,
  input  logic [REG_WIDTH-1:0]               i_reg_2_s,
  input  logic [REG_WIDTH-1:0]               i_reg_3_s,
  input  logic [REG_WIDTH-1:0]               i_reg_4_s,
  input  logic [REG_WIDTH-1:0]               i_reg_5_s,
  input  logic [REG_WIDTH-1:0]               i_reg_6_s,
  input  logic [REG_WIDTH-1:0]               i_reg_7_s,
  input  logic [REG_WIDTH-1:0]               i_reg_8_s,
  input  logic                               i_tx_ready,
  output logic [REG_WIDTH-1:0]               o_tx_data,
  output logic                               o_tx_valid,
  output logic                               o_tx_side,
  output logic                               o_tx_last,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    o_fifo_level,
  output logic                               o_fifo_full,
  output logic [CNT_WIDTH-1:0]               o_drop_count
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = $clog2(FIFO_DEPTH + 1);
  localparam int IDX_W = $clog2(NUM_REGS);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REGS - 1);

  typedef logic [NUM_REGS-1:0][REG_WIDTH-1:0] msg_t;
  typedef struct packed {
    msg_t sell;
    msg_t buy;
  } entry_t;
  typedef enum logic [1:0] {IDLE, SEND_BUY, SEND_SELL} state_t;

  entry_t           mem [FIFO_DEPTH];
  entry_t           in_entry;
  entry_t           head;
  entry_t           next_head;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] rd_ptr_inc;
  logic [LVL_W-1:0] level_next;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] idx_inc;
  state_t           state;
  logic             xfer;
  logic             pop;
  logic             push;
  logic             drop;

  assign in_entry.buy  = {i_reg_8_b, i_reg_7_b, i_reg_6_b, i_reg_5_b, i_reg_4_b,
                          i_reg_3_b, i_reg_2_b, i_reg_1_b, i_reg_0_b};
  assign in_entry.sell = {i_reg_8_s, i_reg_7_s, i_reg_6_s, i_reg_5_s, i_reg_4_s,
                          i_reg_3_s, i_reg_2_s, i_reg_1_s, i_reg_0_s};

  assign xfer       = o_tx_valid && i_tx_ready;
  assign pop        = xfer && (state == SEND_SELL) && (idx == IDX_LAST);
  assign push       = i_valid && (!o_fifo_full || pop);
  assign drop       = i_valid && !push;
  assign rd_ptr_inc = rd_ptr + PTR_W'(1);
  assign idx_inc    = idx + IDX_W'(1);
  assign head       = mem[rd_ptr];
  // With a single entry left, a follow-on pair can only be the one being written right now.
  assign next_head  = (o_fifo_level == LVL_W'(1)) ? in_entry : mem[rd_ptr_inc];

  always_comb begin
    level_next = o_fifo_level;
    if (push && !pop)      level_next = o_fifo_level + LVL_W'(1);
    else if (pop && !push) level_next = o_fifo_level - LVL_W'(1);
  end

  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr] <= in_entry;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      o_fifo_level <= '0;
      o_fifo_full  <= 1'b0;
      o_drop_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr_inc;
      o_fifo_level <= level_next;
      o_fifo_full  <= (level_next == LVL_W'(FIFO_DEPTH));
      if (drop && (o_drop_count != {CNT_WIDTH{1'b1}}))
        o_drop_count <= o_drop_count + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state      <= IDLE;
      idx        <= '0;
      o_tx_valid <= 1'b0;
      o_tx_data  <= '0;
      o_tx_side  <= 1'b0;
      o_tx_last  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (o_fifo_level != '0) begin
            state      <= SEND_BUY;
            idx        <= '0;
            o_tx_valid <= 1'b1;
            o_tx_side  <= 1'b0;
            o_tx_last  <= (IDX_LAST == '0);
            o_tx_data  <= head.buy[0];
          end
        end
        SEND_BUY: begin
          if (xfer) begin
            if (idx == IDX_LAST) begin
              state     <= SEND_SELL;
              idx       <= '0;
              o_tx_side <= 1'b1;
              o_tx_last <= (IDX_LAST == '0);
              o_tx_data <= head.sell[0];
            end else begin
              idx       <= idx_inc;
              o_tx_last <= (idx_inc == IDX_LAST);
              o_tx_data <= head.buy[idx_inc];
            end
          end
        end
        SEND_SELL: begin
          if (xfer) begin
            if (idx == IDX_LAST) begin
              idx <= '0;
              if (level_next != '0) begin
                state      <= SEND_BUY;
                o_tx_side  <= 1'b0;
                o_tx_last  <= (IDX_LAST == '0);
                o_tx_data  <= next_head.buy[0];
              end else begin
                state      <= IDLE;
                o_tx_valid <= 1'b0;
                o_tx_side  <= 1'b0;
                o_tx_last  <= 1'b0;
                o_tx_data  <= '0;
              end
            end else begin
              idx       <= idx_inc;
              o_tx_last <= (idx_inc == IDX_LAST);
              o_tx_data <= head.sell[idx_inc];
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_order_tx_serializer.sv
// Directed bench for order_tx_serializer: table-driven stream checks plus multi-cycle corner sequences.
module tb_order_tx_serializer;
  logic        i_clk;
  logic        i_reset_n;
  logic        i_valid;
  logic        i_tx_ready;
  logic [31:0] buy_w [9];
  logic [31:0] sell_w [9];
  logic [31:0] o_tx_data;
  logic        o_tx_valid;
  logic        o_tx_side;
  logic        o_tx_last;
  logic [2:0]  o_fifo_level;
  logic        o_fifo_full;
  logic [15:0] o_drop_count;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        ready;
    logic        exp_valid;
    logic [31:0] exp_data;
    logic        exp_side;
    logic        exp_last;
  } vec_t;
  vec_t tbl[$];

  order_tx_serializer dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_valid(i_valid),
    .i_reg_0_b(buy_w[0]), .i_reg_1_b(buy_w[1]), .i_reg_2_b(buy_w[2]),
    .i_reg_3_b(buy_w[3]), .i_reg_4_b(buy_w[4]), .i_reg_5_b(buy_w[5]),
    .i_reg_6_b(buy_w[6]), .i_reg_7_b(buy_w[7]), .i_reg_8_b(buy_w[8]),
    .i_reg_0_s(sell_w[0]), .i_reg_1_s(sell_w[1]), .i_reg_2_s(sell_w[2]),
    .i_reg_3_s(sell_w[3]), .i_reg_4_s(sell_w[4]), .i_reg_5_s(sell_w[5]),
    .i_reg_6_s(sell_w[6]), .i_reg_7_s(sell_w[7]), .i_reg_8_s(sell_w[8]),
    .i_tx_ready(i_tx_ready), .o_tx_data(o_tx_data), .o_tx_valid(o_tx_valid),
    .o_tx_side(o_tx_side), .o_tx_last(o_tx_last), .o_fifo_level(o_fifo_level),
    .o_fifo_full(o_fifo_full), .o_drop_count(o_drop_count)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Pair n: buy word k = 0x100*(2n+1)+k, sell word k = 0x100*(2n+2)+k; k 0..17 spans buy then sell.
  function automatic logic [31:0] exp_word(input int n, input int k);
    int hi;
    hi = 2 * n + 1 + ((k >= 9) ? 1 : 0);
    return 32'(hi * 256 + (k % 9));
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic load_pair(input int n);
    for (int k = 0; k < 9; k++) begin
      buy_w[k]  = exp_word(n, k);
      sell_w[k] = exp_word(n, k + 9);
    end
  endtask

  task automatic push_pair(input int n);
    load_pair(n);
    i_valid = 1'b1;
    step();
    i_valid = 1'b0;
  endtask

  task automatic chk_word(input int n, input int k);
    chk("tx_valid", 32'(o_tx_valid), 32'd1);
    chk("tx_data",  o_tx_data, exp_word(n, k));
    chk("tx_side",  32'(o_tx_side), (k >= 9) ? 32'd1 : 32'd0);
    chk("tx_last",  32'(o_tx_last), (k == 8 || k == 17) ? 32'd1 : 32'd0);
  endtask

  task automatic stream(input int n0, input int npairs);
    for (int p = 0; p < npairs; p++)
      for (int k = 0; k < 18; k++) begin
        chk_word(n0 + p, k);
        step();
      end
  endtask

  task automatic do_reset();
    i_reset_n = 1'b0;
    #1;
    i_reset_n = 1'b1;
  endtask

  task automatic build_table(input int mode);
    vec_t v;
    int   k;
    int   i;
    tbl.delete();
    k = 0;
    i = 0;
    while (k < 18) begin
      v.ready     = (mode == 0) ? 1'b1 : ((i % 3) == 0);
      v.exp_valid = 1'b1;
      v.exp_data  = exp_word(0, k);
      v.exp_side  = (k >= 9);
      v.exp_last  = (k == 8 || k == 17);
      tbl.push_back(v);
      if (v.ready) k++;
      i++;
    end
    v.ready = 1'b1; v.exp_valid = 1'b0; v.exp_data = '0; v.exp_side = 1'b0; v.exp_last = 1'b0;
    tbl.push_back(v);
  endtask

  initial begin
    i_reset_n  = 1'b0;
    i_valid    = 1'b0;
    i_tx_ready = 1'b0;
    load_pair(0);
    #2;
    chk("rst_valid", 32'(o_tx_valid), 32'd0);
    chk("rst_data",  o_tx_data, 32'd0);
    chk("rst_side",  32'(o_tx_side), 32'd0);
    chk("rst_last",  32'(o_tx_last), 32'd0);
    chk("rst_level", 32'(o_fifo_level), 32'd0);
    chk("rst_full",  32'(o_fifo_full), 32'd0);
    chk("rst_drop",  32'(o_drop_count), 32'd0);
    step();
    i_reset_n = 1'b1;

    // Single pair at full ready, then the same pair under 1,0,0 ready backpressure.
    for (int mode = 0; mode < 2; mode++) begin
      build_table(mode);
      i_tx_ready = 1'b1;
      push_pair(0);
      chk("cyc1_valid", 32'(o_tx_valid), 32'd0);
      chk("cyc1_level", 32'(o_fifo_level), 32'd1);
      step();
      foreach (tbl[i]) begin
        chk("tbl_valid", 32'(o_tx_valid), 32'(tbl[i].exp_valid));
        chk("tbl_data",  o_tx_data, tbl[i].exp_data);
        chk("tbl_side",  32'(o_tx_side), 32'(tbl[i].exp_side));
        chk("tbl_last",  32'(o_tx_last), 32'(tbl[i].exp_last));
        i_tx_ready = tbl[i].ready;
        step();
      end
      chk("tbl_end_level", 32'(o_fifo_level), 32'd0);
    end

    // Overflow: six pulses against a stalled output, first four kept.
    do_reset();
    i_tx_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      push_pair(i + 1);
      if (i == 3) begin
        chk("ovf_full",  32'(o_fifo_full), 32'd1);
        chk("ovf_level", 32'(o_fifo_level), 32'd4);
      end
    end
    chk("ovf_drop", 32'(o_drop_count), 32'd2);
    i_tx_ready = 1'b1;
    stream(1, 4);
    chk("ovf_end_valid", 32'(o_tx_valid), 32'd0);
    chk("ovf_end_level", 32'(o_fifo_level), 32'd0);
    chk("ovf_end_drop",  32'(o_drop_count), 32'd2);

    // Full FIFO accepts a pair on the edge that pops the head.
    do_reset();
    i_tx_ready = 1'b0;
    for (int i = 1; i <= 4; i++) push_pair(i);
    i_tx_ready = 1'b1;
    for (int k = 0; k < 17; k++) begin
      chk_word(1, k);
      step();
    end
    chk_word(1, 17);
    load_pair(5);
    i_valid = 1'b1;
    step();
    i_valid = 1'b0;
    chk("fp_level", 32'(o_fifo_level), 32'd4);
    chk("fp_full",  32'(o_fifo_full), 32'd1);
    chk("fp_drop",  32'(o_drop_count), 32'd0);
    stream(2, 4);
    chk("fp_end_valid", 32'(o_tx_valid), 32'd0);
    chk("fp_end_level", 32'(o_fifo_level), 32'd0);

    // Back-to-back: three queued pairs give 54 contiguous words.
    do_reset();
    i_tx_ready = 1'b0;
    for (int i = 1; i <= 3; i++) push_pair(i);
    i_tx_ready = 1'b1;
    stream(1, 3);
    chk("b2b_end_valid", 32'(o_tx_valid), 32'd0);

    // Reset while buy word 4 is on the bus, then a fresh pair from word 0.
    do_reset();
    i_tx_ready = 1'b1;
    push_pair(1);
    step();
    for (int k = 0; k < 4; k++) begin
      chk_word(1, k);
      step();
    end
    chk("mid_word4", o_tx_data, exp_word(1, 4));
    i_reset_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(o_tx_valid), 32'd0);
    chk("mid_rst_data",  o_tx_data, 32'd0);
    chk("mid_rst_level", 32'(o_fifo_level), 32'd0);
    chk("mid_rst_last",  32'(o_tx_last), 32'd0);
    #1;
    i_reset_n = 1'b1;
    push_pair(7);
    chk("mid_cyc1_valid", 32'(o_tx_valid), 32'd0);
    step();
    stream(7, 1);
    chk("mid_end_valid", 32'(o_tx_valid), 32'd0);
    chk("mid_end_level", 32'(o_fifo_level), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
